alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one registered ALU between two requesters (0 and 1) with valid/ready handshakes on request and response. One operation is in flight at a time. The block sits between the execute-stage issuers (the datapath and the auxiliary address/compare unit) and the ALU. It sequences every operation through a three-state FSM and returns the result and zero flag to the requester that issued it.

## Interface
- `WORD_SIZE`, default 32 (global define): operand and result width.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid[1:0]`, input, 2: request `i` presents an operation.
- `req_ready[1:0]`, output, 2: request `i` is accepted this cycle when `req_valid[i] & req_ready[i]`.
- `req_op0` / `req_op1`, input, 4 each: ALU opcode for requester 0 / 1.
- `req_a0` / `req_a1`, `req_b0` / `req_b1`, input, `WORD_SIZE` each: operands.
- `rsp_valid[1:0]`, output, 2: response available for requester `i`.
- `rsp_ready[1:0]`, input, 2: requester `i` accepts its response.
- `rsp_result`, output, `WORD_SIZE`: shared result bus, meaningful only with `rsp_valid`.
- `rsp_zero`, output, 1: high when `rsp_result == 0`.
- `busy`, output, 1: high whenever state is not IDLE.

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wraps mod 2^`WORD_SIZE`, no carry out)
  - 0110 SUB (wraps)
  - 0111 result = 1 if a <= b (unsigned), else 0
  - any other code: result 0, zero 1
- FSM states:
  - IDLE: `req_ready[g]` = `req_valid[g]` for the granted index `g`; the other ready bit is 0. On accept, latch op/a/b and the owner index, then go to EXEC.
  - EXEC: ALU registers result and zero at this edge; go to RESP.
  - RESP: `rsp_valid[owner]` = 1, the other bit 0. Result and zero are held stable until `rsp_ready[owner]`, then return to IDLE.
- `req_ready` is 0 in EXEC and RESP, so a new request is never accepted in the response-handshake cycle.
- Grant when both requesters are valid in IDLE: see Configuration. A single valid requester is always granted.
- `req_ready` is combinational from state, grant and `req_valid`. `rsp_valid` is registered-state decode.
- Requesters must hold `req_*` stable while `req_valid` is high and unaccepted. A request is never dropped once valid.
- `rsp_ready` to a non-owner, or outside RESP, is ignored.
- Reset asserted in any state (including mid-EXEC or mid-RESP) aborts the operation. The in-flight response is lost, and no `rsp_valid` is produced for it.

## Timing
- Reset values: state IDLE, `req_ready` 0 until `rst_n` is high, `rsp_valid` 0, `rsp_result` 0, `rsp_zero` 0, `busy` 0, round-robin pointer favours requester 0.
- Accept in cycle T (handshake sampled at edge T+1). EXEC is cycle T+1. `rsp_valid` is high from cycle T+2.
- If `rsp_ready` is high in T+2, the block returns to IDLE in T+3. Peak throughput is one operation per 3 cycles.
- `busy` is high from cycle T+1 through the response-handshake cycle.
- `rsp_result` and `rsp_zero` hold their last values in IDLE.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. On contention, grant the requester not granted last. The pointer updates only on acceptance.
- `ALU_ARB_RR_EN` undefined: fixed priority, requester 0 always wins contention. The pointer register is not built.

## Structure
- Shared package/header holds:
  - opcode constants (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLE`)
  - FSM state encodings `ARB_IDLE`, `ARB_EXEC`, `ARB_RESP` (2 bits)
  - the `WORD_SIZE` define
- One sub-module: `alu_core`, a registered ALU (op, a, b -> result, zero, one-edge latency, with async active-low reset). The arbiter instantiates it once and clocks it only in EXEC via an enable.

## Test plan
- Single request: requester 0, op 0010, a=5, b=7 -> `rsp_valid[0]` at T+2, result 12, zero 0; `rsp_valid[1]` stays 0.
- SUB to zero: requester 1, op 0110, a=b=0x1234 -> result 0, zero 1. ADD with a=0xFFFFFFFF, b=1 -> result 0, zero 1.
- SLE and undefined op: op 0111 with a=3, b=3 -> result 1; a=4, b=3 -> result 0; op 1111 -> result 0, zero 1.
- Contention: both valid continuously for 4 ops. With `ALU_ARB_RR_EN`, grants are 0,1,0,1; without it, grants are 0,0,0,0 and requester 1 is never ready.
- Response backpressure: hold `rsp_ready` low for 5 cycles -> result stable, `req_ready` 0 throughout, IDLE one cycle after `rsp_ready` rises.
- Reset mid-EXEC: deassert `rst_n` in EXEC -> all outputs at reset values immediately, no `rsp_valid` after release, next request behaves normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - opcodes, FSM encodings, WORD_SIZE and ALU evaluation shared by alu_arbiter
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package alu_arbiter_pkg;

    localparam int W = `WORD_SIZE;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLE = 4'b0111;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_EXEC = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    // Undefined opcodes deliberately yield zero so the zero flag reads 1.
    function automatic logic [W-1:0] alu_eval(input logic [3:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_SLE: r = {{(W-1){1'b0}}, (a <= b)};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered ALU with one-edge latency, updated only while en_i is high
module alu_core
    import alu_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o,
    output logic         zero_o
);

    logic [W-1:0] result_q, result_d;
    logic         zero_q;

    assign result_d = alu_eval(op_i, a_i, b_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (en_i) begin
            result_q <= result_d;
            zero_q   <= (result_d == '0);
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one registered ALU
// ALU_ARB_RR_EN selects round-robin contention; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [3:0]   req_op0,
    input  logic [3:0]   req_op1,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_b1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         busy
);

    logic [1:0]   state_q, state_d;
    logic         owner_q, owner_d;
    logic [3:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic         grant;
    logic         accept;

`ifdef ALU_ARB_RR_EN
    // ptr_q names the requester favoured on the next contention.
    logic ptr_q, ptr_d;

    assign grant = (&req_valid) ? ptr_q : req_valid[1];
    assign ptr_d = accept ? ~grant : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
`else
    assign grant = req_valid[1] & ~req_valid[0];
`endif

    always_comb begin
        req_ready = 2'b00;
        if (rst_n && state_q == ARB_IDLE) req_ready[grant] = req_valid[grant];
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ARB_IDLE: if (accept) begin
                state_d = ARB_EXEC;
                owner_d = grant;
                op_d    = grant ? req_op1 : req_op0;
                a_d     = grant ? req_a1  : req_a0;
                b_d     = grant ? req_b1  : req_b0;
            end
            ARB_EXEC: state_d = ARB_RESP;
            ARB_RESP: if (rsp_ready[owner_q]) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            op_q    <= 4'b0000;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (state_q == ARB_RESP) rsp_valid[owner_q] = 1'b1;
    end

    assign busy = (state_q != ARB_IDLE);

    alu_core u_alu_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (state_q == ARB_EXEC),
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (rsp_result),
        .zero_o   (rsp_zero)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized scoreboard bench for alu_arbiter
module tb_alu_arbiter;
    import alu_arbiter_pkg::W;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic [3:0]   op0 = '0, op1 = '0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, busy;

    assign req_valid = {v1, v0};

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(op0), .req_op1(op1),
        .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
    );

    typedef struct {
        bit           owner;
        logic [W-1:0] res;
        bit           zero;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t e, ne;
    int   passed = 0, total = 0, cyc = 0;
    bit   last_g = 1'b1;
    bit   g;
    bit   rsp_rand = 1'b0;
    logic [1:0] rsp_force = 2'b11;

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (a <= b) ? W'(1) : W'(0);
            default: return W'(0);
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rsp_ready = 2'b11;
        forever begin
            @(posedge clk); #1;
            rsp_ready = rsp_rand ? 2'($urandom) : rsp_force;
        end
    end

    // Scoreboard monitor: one accepted request in flight, answered from cycle acc+2.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_g = 1'b1;
            check("rst_req_ready", W'(req_ready), W'(0));
            check("rst_rsp_valid", W'(rsp_valid), W'(0));
            check("rst_rsp_result", rsp_result, W'(0));
            check("rst_rsp_zero", W'(rsp_zero), W'(0));
            check("rst_busy", W'(busy), W'(0));
        end else if (q.size() > 0) begin
            e = q[0];
            check("busy_req_ready", W'(req_ready), W'(0));
            check("busy_flag", W'(busy), W'(1));
            if (cyc >= e.acc + 2) begin
                check("rsp_valid", W'(rsp_valid), e.owner ? W'(2) : W'(1));
                check("rsp_result", rsp_result, e.res);
                check("rsp_zero", W'(rsp_zero), W'(e.zero));
                if (rsp_ready[e.owner]) void'(q.pop_front());
            end else begin
                check("rsp_valid_early", W'(rsp_valid), W'(0));
            end
        end else begin
            check("idle_busy", W'(busy), W'(0));
            check("idle_rsp_valid", W'(rsp_valid), W'(0));
            if (req_valid != 2'b00) begin
                g = (&req_valid) ? (RR ? ~last_g : 1'b0) : req_valid[1];
                check("grant", W'(req_ready), g ? W'(2) : W'(1));
                last_g    = g;
                ne.owner  = g;
                ne.res    = g ? model(op1, a1, b1) : model(op0, a0, b0);
                ne.zero   = (ne.res == '0);
                ne.acc    = cyc;
                q.push_back(ne);
            end else begin
                check("idle_req_ready", W'(req_ready), W'(0));
            end
        end
    end

    task automatic issue(input bit r, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        if (r) begin op1 = op; a1 = a; b1 = b; v1 = 1'b1; end
        else   begin op0 = op; a0 = a; b0 = b; v0 = 1'b1; end
        while (1) begin
            @(negedge clk);
            if (rst_n && req_ready[r]) begin
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 2000) begin
                total++;
                $display("FAIL accept_timeout r%0d: not accepted after %0d cycles, acceptance required", r, n);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (r) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d responses outstanding, 0 required", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0111;
            default: return 4'($urandom);
        endcase
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic rand_stream(input bit r, input int n);
        int k;
        repeat (n) begin
            k = $urandom_range(0, 3);
            if (k != 0) begin
                repeat (k) @(posedge clk);
                #1;
            end
            issue(r, rand_op(), rand_opnd(), rand_opnd());
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(1'b0, 4'b0010, W'(5), W'(7));
        issue(1'b1, 4'b0110, W'('h1234), W'('h1234));
        issue(1'b0, 4'b0010, '1, W'(1));
        issue(1'b1, 4'b0111, W'(3), W'(3));
        issue(1'b0, 4'b0111, W'(4), W'(3));
        issue(1'b1, 4'b1111, W'($urandom), W'($urandom));
        wait_drain();

        // Response backpressure; rsp_ready to the non-owner must be ignored.
        rsp_force = 2'b10;
        issue(1'b0, 4'b0001, W'('hF0), W'('h0F));
        fork
            issue(1'b1, 4'b0010, W'(100), W'(200));
            begin
                repeat (6) @(posedge clk);
                #1 rsp_force = 2'b11;
            end
        join
        wait_drain();

        fork
            repeat (4) issue(1'b0, rand_op(), rand_opnd(), rand_opnd());
            repeat (4) issue(1'b1, rand_op(), rand_opnd(), rand_opnd());
        join
        wait_drain();

        // Reset while the operation is in EXEC: its response must never appear.
        issue(1'b0, 4'b0010, W'(9), W'(9));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue(1'b1, 4'b0010, W'(1), W'(2));
        wait_drain();

        rsp_rand = 1'b1;
        fork
            rand_stream(1'b0, 40);
            rand_stream(1'b1, 40);
        join
        rsp_rand = 1'b0;
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
